sdr_to_ddr_tx: RTL
==================

# sdr_to_ddr_tx

Transmit side of the DDR byte link: accepts pairs of 8-bit SDR words through a valid/ready interface, buffers them in a small FIFO, and drives one word per clock half-phase on a single DDR byte lane. It is the counterpart of the DDR-to-SDR capture block. Word 0 of each pair is driven while `clk` is high and word 1 while `clk` is low, so the capture block returns the same pair as `sdr_data_0` / `sdr_data_1`.

## Interface
- `WIDTH`, 8, lane width in bits.
- `DEPTH`, 4, FIFO depth in pairs; power of two, ≥2.
- `IDLE_WORD`, 8'h00, value driven on both phases when no pair is being sent.

- `clk` in 1: the single clock; `ddr_data` phases are referenced to its level.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid` in 1: an input pair is present.
- `in_ready` out 1: the FIFO can accept a pair; equals `!full && !rst`.
- `in_data_0` in WIDTH: first word of the pair (high phase).
- `in_data_1` in WIDTH: second word of the pair (low phase).
- `tx_en` in 1: transmit enable; when low the FIFO does not drain.
- `ddr_data` out WIDTH: DDR lane; equals `clk ? hi_reg : lo_reg`.
- `ddr_valid` out 1: the current cycle carries a real pair.
- `fifo_level` out $clog2(DEPTH)+1: number of pairs stored.
- `underrun_cnt` out 8: saturating count of underrun events.

## Operation
- Push when `in_valid && in_ready` on a rising edge. The pair is written at `wr_ptr`, and `wr_ptr` wraps modulo DEPTH.
- Pop when state is ACTIVE, `tx_en` is high and the FIFO is not empty. The head is loaded into `hi_reg`/`lo_reg`, `ddr_valid` is set to 1, and `rd_ptr` wraps modulo DEPTH.
- Level update on each edge:
  - push and pop: level unchanged.
  - push only: level + 1.
  - pop only: level − 1.
- `full` is `level==DEPTH`; `empty` is `level==0`.
- When full, `in_ready` is 0, so there is no push. A pop in that cycle frees a slot and `in_ready` rises the next cycle.
- When no pop occurs on an edge, `hi_reg` and `lo_reg` load IDLE_WORD and `ddr_valid` loads 0. The lane never repeats stale data.
- State machine, evaluated at each rising edge:
  - IDLE → ACTIVE when `tx_en && !empty`. A pop happens on that same edge.
  - ACTIVE → ACTIVE when `tx_en && !empty` (pop).
  - ACTIVE → IDLE when `tx_en && empty`. This is an underrun: `underrun_cnt` increments, saturating at 8'hFF.
  - ACTIVE → IDLE when `!tx_en`. This is not an underrun and the FIFO is held.
  - IDLE stays IDLE otherwise, and never counts underruns.
- Ordering is strictly FIFO. Within a cycle, word 0 always precedes word 1 on the lane.

## Timing
- Reset values, reached after one rising edge with `rst=1`:
  - state IDLE, pointers 0, `fifo_level` 0.
  - `hi_reg`/`lo_reg` = IDLE_WORD, so `ddr_data` = IDLE_WORD on both phases.
  - `ddr_valid` 0, `underrun_cnt` 0.
  - `in_ready` is 0 while `rst` is high and becomes 1 on the first cycle after.
- Reset mid-stream discards all FIFO contents and any pair in flight. Pushes presented in the reset cycle are dropped.
- Latency from an accepting push at edge N into an empty FIFO with `tx_en=1` in IDLE:
  - the pair is popped at edge N+1.
  - word 0 is on `ddr_data` during the high phase after edge N+1; word 1 during the following low phase.
  - `ddr_valid` is 1 from N+1 to N+2.
- Sustained throughput is one pair per cycle, with push and pop in the same edge at any level.
- `ddr_data` changes only at clock edges: it switches to `hi_reg` at the rising edge and to `lo_reg` at the falling edge. All registers update on the rising edge only.
- `tx_en` deassert at edge M: the edge-M pop does not occur, and the lane shows IDLE_WORD from M on.

## Test plan
- Reset, then hold `rst=1` for 3 cycles with `in_valid=1` → `in_ready=0`, `fifo_level=0`, `ddr_data=8'h00`, `ddr_valid=0`; no push is recorded.
- Single pair (AA,55) pushed at edge N with `tx_en=1` → `ddr_data`=AA while `clk` is high and 55 while `clk` is low in cycle N+1. `ddr_valid` is 1 for that cycle only, then 00/00. `underrun_cnt` becomes 1.
- `tx_en=0`, push 5 pairs (11/22, 33/44, 55/66, 77/88, 99/AA) → first 4 accepted, `fifo_level=4`, `in_ready=0` on the 5th. After `tx_en=1`, the 5th pair is accepted the cycle after the first pop. The lane then shows all 5 pairs in order, back-to-back with no idle gap, and the counter ends at 1 underrun.
- Continuous push and pop for 20 cycles of incrementing data → `fifo_level` stays 0/1 (steady state 1 after the first cycle). Every pair appears exactly once, in order, with `ddr_valid` continuously 1. Pointer wrap-around is crossed at least 4 times.
- Assert `rst` mid-stream with 3 pairs queued → at the next edge `fifo_level=0`, `ddr_valid=0`, the lane shows IDLE_WORD and `underrun_cnt=0`. No queued pair is ever emitted afterward.
- 300 isolated single-pair bursts → `underrun_cnt` saturates at 8'hFF and does not wrap.

Source files
------------

// File: rtl/sdr_to_ddr_tx_if.sv
// Input pair handshake for the DDR byte-lane transmitter.
interface sdr_to_ddr_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data_0;
    logic [WIDTH-1:0] in_data_1;

    modport master (
        output in_valid,
        output in_data_0,
        output in_data_1,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data_0,
        input  in_data_1,
        output in_ready
    );
endinterface

// File: rtl/sdr_to_ddr_tx.sv
// SDR-to-DDR transmitter: buffers word pairs in a FIFO and drives word 0 while clk is
// high and word 1 while clk is low on a single lane.
module sdr_to_ddr_tx #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    sdr_to_ddr_tx_if.slave           in_if,
    input  logic                     tx_en_i,
    output logic [WIDTH-1:0]         ddr_data_o,
    output logic                     ddr_valid_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic [7:0]               underrun_cnt_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic {StIdle, StActive} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             valid_q;
    logic [7:0]       ucnt_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic underrun;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    // Ready drops combinationally during reset so reset-cycle pushes are dropped.
    assign in_if.in_ready = !full && !rst;
    assign push     = in_if.in_valid && in_if.in_ready;
    // A pop happens from either state; IDLE simply moves to ACTIVE on it.
    assign pop      = tx_en_i && !empty;
    assign underrun = (state_q == StActive) && tx_en_i && empty;

    // Pair storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0_q[wr_ptr_q] <= in_if.in_data_0;
            mem1_q[wr_ptr_q] <= in_if.in_data_1;
        end
    end

    // Control FSM, pointers, level and registered lane outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hi_q     <= IDLE_WORD;
            lo_q     <= IDLE_WORD;
            valid_q  <= 1'b0;
            ucnt_q   <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            // The lane never repeats stale data: no pop means idle words.
            if (pop) begin
                hi_q     <= mem0_q[rd_ptr_q];
                lo_q     <= mem1_q[rd_ptr_q];
                valid_q  <= 1'b1;
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end else begin
                hi_q    <= IDLE_WORD;
                lo_q    <= IDLE_WORD;
                valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle:   state_q <= pop ? StActive : StIdle;
                StActive: state_q <= pop ? StActive : StIdle;
                default:  state_q <= StIdle;
            endcase

            if (underrun && ucnt_q != 8'hFF) begin
                ucnt_q <= ucnt_q + 8'd1;
            end
        end
    end

    // Word 0 on the high phase, word 1 on the low phase.
    assign ddr_data_o     = clk ? hi_q : lo_q;
    assign ddr_valid_o    = valid_q;
    assign fifo_level_o   = level_q;
    assign underrun_cnt_o = ucnt_q;
endmodule
